// File: rtl/alu_seq_muldiv_pkg.sv
//==============================================================================
// alu_seq_muldiv_pkg : opcodes, FSM states and muldiv sub-op indices
// Rev 1.0
//==============================================================================
`default_nettype none

package alu_seq_muldiv_pkg;

  localparam int unsigned ALU_ADDJ   = 0;
  localparam int unsigned ALU_ADD    = 1;
  localparam int unsigned ALU_SUB    = 2;
  localparam int unsigned ALU_AND    = 3;
  localparam int unsigned ALU_OR     = 4;
  localparam int unsigned ALU_XOR    = 5;
  localparam int unsigned ALU_SLL    = 6;
  localparam int unsigned ALU_SRL    = 7;
  localparam int unsigned ALU_SRA    = 8;
  localparam int unsigned ALU_PASSB  = 9;
  localparam int unsigned ALU_SLT    = 10;
  localparam int unsigned ALU_SLTU   = 11;
  localparam int unsigned ALU_MUL    = 12;
  localparam int unsigned ALU_MULH   = 13;
  localparam int unsigned ALU_MULHSU = 14;
  localparam int unsigned ALU_MULHU  = 15;
  localparam int unsigned ALU_DIV    = 16;
  localparam int unsigned ALU_DIVU   = 17;
  localparam int unsigned ALU_REM    = 18;
  localparam int unsigned ALU_REMU   = 19;

  // Engine sub-op index = opcode - ALU_MUL
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [31:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_muldiv_if.sv
//==============================================================================
// alu_seq_muldiv_if : issue and result handshake bundle
// Rev 1.0
//==============================================================================
`default_nettype none

interface alu_seq_muldiv_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  aluop;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, aluop, op_a, op_b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, aluop, op_a, op_b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

`default_nettype wire

// File: rtl/alu_seq_muldiv_muldiv_iter.sv
//==============================================================================
// alu_seq_muldiv_muldiv_iter : one-bit-per-cycle shift-add multiply / restoring divide
// Rev 1.0
//==============================================================================
`default_nettype none

module alu_seq_muldiv_muldiv_iter
  import alu_seq_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] C_LAST = CW'(XLEN - 1);

  logic            r_active;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_m;
  logic            r_neg_lo;
  logic            r_neg_rem;

  logic              w_a_s, w_b_s;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic [XLEN:0]     w_sum, w_shift, w_diff;
  logic [XLEN-1:0]   w_hi_n, w_lo_n;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix;

  // Signed operands are reduced to magnitudes; signs are re-applied on the last step
  assign w_a_s   = a[XLEN-1] & (op != MD_MULHU) & (op != MD_DIVU) & (op != MD_REMU);
  assign w_b_s   = b[XLEN-1] & ((op == MD_MUL) | (op == MD_MULH) | (op == MD_DIV) | (op == MD_REM));
  assign w_a_mag = w_a_s ? ('0 - a) : a;
  assign w_b_mag = w_b_s ? ('0 - b) : b;

  // r_lo holds the multiplier (mul) or the dividend/quotient (div); r_hi is partial product / remainder
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_m};

  always_comb begin
    w_hi_n = r_hi;
    w_lo_n = r_lo;
    if (r_op[2]) begin
      if (!w_diff[XLEN]) begin
        w_hi_n = w_diff[XLEN-1:0];
        w_lo_n = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_n = w_shift[XLEN-1:0];
        w_lo_n = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_n = w_sum[XLEN:1];
      w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  assign w_prod     = {w_hi_n, w_lo_n};
  assign w_prod_fix = r_neg_lo  ? ('0 - w_prod) : w_prod;
  assign w_quo_fix  = r_neg_lo  ? ('0 - w_lo_n) : w_lo_n;
  assign w_rem_fix  = r_neg_rem ? ('0 - w_hi_n) : w_hi_n;

  always_comb begin
    result = '0;
    case (r_op)
      MD_MUL:                      result = w_prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = w_prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             result = w_quo_fix;
      default:                     result = w_rem_fix;
    endcase
  end

  assign done = r_active && (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_cnt     <= '0;
      r_op      <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_m       <= '0;
      r_neg_lo  <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (flush) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (start) begin
      r_active  <= 1'b1;
      r_cnt     <= '0;
      r_op      <= op;
      r_hi      <= '0;
      r_lo      <= w_a_mag;
      r_m       <= w_b_mag;
      r_neg_lo  <= w_a_s ^ w_b_s;
      r_neg_rem <= w_a_s;
    end else if (r_active) begin
      r_hi <= w_hi_n;
      r_lo <= w_lo_n;
      if (done) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
//==============================================================================
// alu_seq_muldiv : handshaked registered ALU with iterative RV-M multiply/divide
// Rev 1.0
//==============================================================================
`default_nettype none

module alu_seq_muldiv
  import alu_seq_muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  output logic              busy,
  alu_seq_muldiv_if.slave   bus
);

  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state, w_state_n;
  logic [XLEN-1:0] r_result;

  logic [31:0]     w_op;
  logic [2:0]      w_md_idx;
  logic            w_accept, w_is_md, w_fast, w_start;
  logic            w_div_zero, w_ovf, w_is_divrem, w_is_sdiv;
  logic [SW-1:0]   w_shamt;
  logic [XLEN-1:0] w_sum, w_diff, w_imm_result, w_eng_result;
  logic            w_eng_done;

  assign w_op     = 32'(bus.aluop);
  assign w_md_idx = 3'(w_op - ALU_MUL);
  assign w_is_md  = is_muldiv(w_op);
  assign w_shamt  = bus.op_b[SW-1:0];
  assign w_sum    = bus.op_a + bus.op_b;
  assign w_diff   = bus.op_a - bus.op_b;

  // Divide-by-zero and MIN/-1 finish in one cycle without starting the engine
  assign w_div_zero  = (bus.op_b == '0);
  assign w_ovf       = (bus.op_a == C_MIN) && (bus.op_b == '1);
  assign w_is_divrem = (w_op >= ALU_DIV) && (w_op <= ALU_REMU);
  assign w_is_sdiv   = (w_op == ALU_DIV) || (w_op == ALU_REM);
  assign w_fast      = (w_is_divrem && w_div_zero) || (w_is_sdiv && w_ovf);

  assign bus.in_ready  = !flush && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready));
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_start       = w_accept && w_is_md && !w_fast;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.result    = r_result;
  assign busy          = (r_state == ST_BUSY);

  always_comb begin
    w_imm_result = '0;
    case (w_op)
      ALU_ADDJ:  w_imm_result = {w_sum[XLEN-1:1], 1'b0};
      ALU_ADD:   w_imm_result = w_sum;
      ALU_SUB:   w_imm_result = w_diff;
      ALU_AND:   w_imm_result = bus.op_a & bus.op_b;
      ALU_OR:    w_imm_result = bus.op_a | bus.op_b;
      ALU_XOR:   w_imm_result = bus.op_a ^ bus.op_b;
      ALU_SLL:   w_imm_result = bus.op_a << w_shamt;
      ALU_SRL:   w_imm_result = bus.op_a >> w_shamt;
      ALU_SRA:   w_imm_result = $signed(bus.op_a) >>> w_shamt;
      ALU_PASSB: w_imm_result = bus.op_b;
      ALU_SLT:   w_imm_result = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      ALU_SLTU:  w_imm_result = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
      ALU_DIV:   w_imm_result = w_div_zero ? '1 : C_MIN;
      ALU_DIVU:  w_imm_result = '1;
      ALU_REM:   w_imm_result = w_div_zero ? bus.op_a : '0;
      ALU_REMU:  w_imm_result = bus.op_a;
      default:   w_imm_result = '0;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    if (flush) begin
      w_state_n = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_n = w_start ? ST_BUSY : ST_DONE;
        ST_BUSY: if (w_eng_done) w_state_n = ST_DONE;
        ST_DONE: begin
          if (bus.out_ready) begin
            if (!w_accept)    w_state_n = ST_IDLE;
            else if (w_start) w_state_n = ST_BUSY;
            else              w_state_n = ST_DONE;
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else if (!flush) begin
      if (w_accept && !w_start) r_result <= w_imm_result;
      else if (w_eng_done)      r_result <= w_eng_result;
    end
  end

  alu_seq_muldiv_muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (w_start),
    .op     (w_md_idx),
    .a      (bus.op_a),
    .b      (bus.op_b),
    .done   (w_eng_done),
    .result (w_eng_result)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_muldiv.sv
//==============================================================================
// tb_alu_seq_muldiv : scoreboard bench with arithmetic reference model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_alu_seq_muldiv;
  import alu_seq_muldiv_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;

  alu_seq_muldiv_if #(.XLEN(XLEN), .OPW(5)) bus ();

  alu_seq_muldiv #(.XLEN(XLEN), .OPW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   bp_en = 1'b0;

  // Reference: RV-M results from plain 64-bit arithmetic
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [4:0] sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sh = b[4:0];
    case (op)
      5'd0:  return (a + b) & 32'hFFFF_FFFE;
      5'd1:  return a + b;
      5'd2:  return a - b;
      5'd3:  return a & b;
      5'd4:  return a | b;
      5'd5:  return a ^ b;
      5'd6:  return a << sh;
      5'd7:  return a >> sh;
      5'd8:  return $signed(a) >>> sh;
      5'd9:  return b;
      5'd10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd11: return (a < b) ? 32'd1 : 32'd0;
      5'd12: begin p = sa * sb; return p[31:0];  end
      5'd13: begin p = sa * sb; return p[63:32]; end
      5'd14: begin p = sa * ub; return p[63:32]; end
      5'd15: begin p = ua * ub; return p[63:32]; end
      5'd16: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      5'd17: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      5'd18: return (b == 0) ? a : 32'(sa % sb);
      5'd19: return (b == 0) ? a : 32'(ua % ub);
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.exp = ref_alu(op, a, b);
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: compares every result handed over to the consumer
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got %h with no result due", bus.result);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.result !== mon_e.exp) begin
          n_err++;
          $display("FAIL result op=%0d a=%h b=%h: got %h, expected %h",
                   mon_e.op, mon_e.a, mon_e.b, bus.result, mon_e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    int n;
    bus.in_valid = 1'b1;
    bus.aluop    = op;
    bus.op_a     = a;
    bus.op_b     = b;
    if (push) push_exp(op, a, b);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL issue_timeout: in_ready=%b after %0d cycles, expected 1", bus.in_ready, n);
        break;
      end
      tick();
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 8));
      default: return 32'($urandom);
    endcase
  endfunction

  logic [4:0]  base_op [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd25};
  logic [31:0] base_a  [13] = '{32'h3, 32'hFFFF_FFFF, 32'h0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                                32'h1, 32'h8000_0000, 32'hFFF0_0000, 32'h1234_5678, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'h1};
  logic [31:0] base_b  [13] = '{32'h2, 32'h1, 32'h1, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00,
                                32'h0000_003F, 32'h4, 32'h8, 32'hCAFE_F00D, 32'h1, 32'h1, 32'h1};

  initial begin
    int bad;
    logic [4:0] rop;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.aluop     = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset_busy",      {31'b0, busy},          32'd0);
    chk("reset_result",    bus.result,             32'd0);
    chk("reset_in_ready",  {31'b0, bus.in_ready},  32'd1);
    tick();

    // Base and illegal ops: one-cycle latency
    for (int i = 0; i < 13; i++) begin
      issue(base_op[i], base_a[i], base_b[i], 1'b1);
      @(negedge clk);
      chk("latency_base", {31'b0, bus.out_valid}, 32'd1);
      tick();
    end
    drain();

    // Multiply timing: busy for XLEN cycles, result on cycle XLEN+1
    issue(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (!(busy === 1'b1 && bus.in_ready === 1'b0 && bus.out_valid === 1'b0)) bad++;
    end
    chk("mul_busy_cycles_bad", 32'(bad), 32'd0);
    @(negedge clk);
    chk("mul_out_valid_c33", {31'b0, bus.out_valid}, 32'd1);
    tick();
    issue(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(5'd16, 32'hFFFF_FFF9, 32'h2, 1'b1);
    issue(5'd18, 32'hFFFF_FFF9, 32'h2, 1'b1);
    drain();

    // Fast-path divide cases complete in one cycle
    issue(5'd17, 32'h7, 32'h0, 1'b1);
    @(negedge clk);
    chk("latency_divu_zero", {31'b0, bus.out_valid}, 32'd1);
    tick();
    issue(5'd19, 32'h7, 32'h0, 1'b1);
    @(negedge clk);
    chk("latency_remu_zero", {31'b0, bus.out_valid}, 32'd1);
    tick();
    issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    chk("latency_div_ovf", {31'b0, bus.out_valid}, 32'd1);
    tick();
    issue(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    drain();

    // Back-pressure: result held, no accept, then release with a new op
    bus.out_ready = 1'b0;
    issue(5'd1, 32'h3, 32'h2, 1'b1);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!(bus.out_valid === 1'b1 && bus.result === 32'd5 && bus.in_ready === 1'b0)) bad++;
      tick();
    end
    chk("backpressure_hold_bad", 32'(bad), 32'd0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.aluop     = 5'd1;
    bus.op_a      = 32'h1;
    bus.op_b      = 32'h2;
    push_exp(5'd1, 32'h1, 32'h2);
    @(negedge clk);
    chk("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("release_next_valid", {31'b0, bus.out_valid}, 32'd1);
    drain();

    // Flush during BUSY cycle 16 of divu
    issue(5'd17, 32'($urandom), 32'($urandom) | 32'h1, 1'b0);
    repeat (15) tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {30'b0, busy, bus.in_ready}, 32'd1);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("flush_no_valid", 32'(bad), 32'd0);
    tick();
    issue(5'd1, 32'h1, 32'h1, 1'b1);
    drain();

    // Asynchronous reset during BUSY cycle 10 of mul
    issue(5'd12, 32'($urandom), 32'($urandom), 1'b0);
    repeat (9) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("arst_busy",      {31'b0, busy},          32'd0);
    chk("arst_result",    bus.result,             32'd0);
    chk("arst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    issue(5'd15, 32'h8000_0000, 32'h2, 1'b1);
    drain();

    // Randomized traffic with random consumer back-pressure
    bp_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) rop = 5'(12 + $urandom_range(0, 7));
      else                           rop = 5'($urandom_range(0, 31));
      issue(rop, rnd_operand(), rnd_operand(), 1'b1);
    end
    bp_en = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
